// File: rtl/np_frame_sequencer.sv
// Pixel frame buffer and sequencer: holds up to NPIX GRB colours, scales them by a
// global brightness and streams one frame to the NeoPixel serializer per start command.
module np_frame_sequencer #(
    parameter int NPIX = 8
) (
    input  logic        pclk,
    input  logic        nreset,
    input  logic        bus_write_en,
    input  logic        bus_read_en,
    input  logic        fb_en,
    input  logic [7:0]  bus_addr,
    input  logic [31:0] bus_write_data,
    output logic [31:0] bus_read_data,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    output logic        pix_last,
    input  logic        pix_ready,
    output logic        frame_done
);

    typedef enum logic [1:0] {IDLE, LOAD, OFFER, DONE} state_t;

    localparam logic [4:0] NPIX_LEN    = 5'(NPIX);
    localparam logic [5:0] NPIX_WORDS  = 6'(NPIX);
    localparam logic [5:0] ADDR_LEN    = 6'h10;
    localparam logic [5:0] ADDR_BRIGHT = 6'h11;
    localparam logic [5:0] ADDR_CTRL   = 6'h12;
    localparam logic [5:0] ADDR_STATUS = 6'h13;

    state_t      state, next_state;
    logic [23:0] pix_buf [16];
    logic [4:0]  len_q;
    logic [7:0]  bright_q;
    logic [3:0]  idx;
    logic        done_q;

    logic [5:0]  word;
    logic        wr_sel, rd_sel, cfg_open, busy;
    logic        pix_wr, len_wr, bright_wr, ctrl_wr;
    logic        start_cmd, clear_cmd, clear_done;
    logic [4:0]  len_in;
    logic [23:0] cur_pix;
    logic        idx_last, xfer;
    logic        unused_bits;

    assign word        = bus_addr[7:2];
    assign wr_sel      = bus_write_en & fb_en;
    assign rd_sel      = bus_read_en & fb_en;
    assign busy        = (state != IDLE);
    // The DONE cycle falls straight back to IDLE, so writes landing on it count as idle writes.
    assign cfg_open    = (state == IDLE) || (state == DONE);
    assign pix_wr      = wr_sel & cfg_open & (word < NPIX_WORDS);
    assign len_wr      = wr_sel & cfg_open & (word == ADDR_LEN);
    assign bright_wr   = wr_sel & cfg_open & (word == ADDR_BRIGHT);
    assign ctrl_wr     = wr_sel & (word == ADDR_CTRL);
    assign clear_cmd   = ctrl_wr & cfg_open & bus_write_data[1];
    assign start_cmd   = ctrl_wr & cfg_open & bus_write_data[0] & ~bus_write_data[1];
    assign clear_done  = ctrl_wr & bus_write_data[2];
    assign len_in      = bus_write_data[4:0];
    assign cur_pix     = pix_buf[idx];
    assign idx_last    = ({1'b0, idx} == (len_q - 5'd1));
    assign xfer        = pix_valid & pix_ready;
    assign pix_valid   = (state == OFFER);
    assign frame_done  = (state == DONE);
    assign unused_bits = ^{bus_addr[1:0], bus_write_data[31:24]};

    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'h00, c} * ({8'h00, b} + 16'd1);
        return 8'(prod >> 8);
    endfunction

    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_cmd) next_state = LOAD;
            LOAD:    next_state = OFFER;
            OFFER:   if (xfer) next_state = pix_last ? DONE : LOAD;
            DONE:    next_state = start_cmd ? LOAD : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // idx returns to 0 on the last transfer so STATUS reads a clean index once the frame ends.
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < 16; i++) pix_buf[i] <= '0;
            len_q    <= NPIX_LEN;
            bright_q <= 8'hFF;
            idx      <= '0;
            done_q   <= 1'b0;
            pix_data <= '0;
            pix_last <= 1'b0;
        end else begin
            if (clear_cmd) begin
                for (int i = 0; i < 16; i++) pix_buf[i] <= '0;
            end else if (pix_wr) begin
                pix_buf[word[3:0]] <= bus_write_data[23:0];
            end
            if (len_wr)
                len_q <= ((len_in == 5'd0) || (len_in > NPIX_LEN)) ? NPIX_LEN : len_in;
            if (bright_wr)
                bright_q <= bus_write_data[7:0];
            if (state == DONE)
                done_q <= 1'b1;
            else if (clear_done)
                done_q <= 1'b0;
            if (start_cmd) begin
                idx <= '0;
            end else if (state == LOAD) begin
                pix_data <= {scale8(cur_pix[23:16], bright_q),
                             scale8(cur_pix[15:8], bright_q),
                             scale8(cur_pix[7:0], bright_q)};
                pix_last <= idx_last;
            end else if ((state == OFFER) && xfer) begin
                idx <= pix_last ? 4'd0 : idx + 4'd1;
            end
        end
    end

    always_comb begin
        bus_read_data = '0;
        if (rd_sel) begin
            if (word < NPIX_WORDS) begin
                bus_read_data = {8'h00, pix_buf[word[3:0]]};
            end else begin
                case (word)
                    ADDR_LEN:    bus_read_data = {27'b0, len_q};
                    ADDR_BRIGHT: bus_read_data = {24'b0, bright_q};
                    ADDR_STATUS: bus_read_data = {26'b0, done_q, busy, idx};
                    default:     bus_read_data = '0;
                endcase
            end
        end
    end

endmodule

// File: doc/np_frame_sequencer.md
# np_frame_sequencer

Pixel frame buffer and sequencer sitting directly upstream of the NeoPixel serializer on the same CPU bus. Software writes up to `NPIX` 24-bit GRB colours into an internal buffer, sets a frame length and global brightness, then issues a start command. The block brightness-scales each pixel and streams the pixels in index order to the serializer over a valid/ready handshake, flagging the last pixel of the frame.

## Interface
- `NPIX`, 8: pixel buffer depth; legal range 1..16.
- `pclk` in 1: clock; all state on the rising edge.
- `nreset` in 1: asynchronous active-low reset.
- `bus_write_en` in 1: bus write strobe, valid one cycle.
- `bus_read_en` in 1: bus read strobe.
- `fb_en` in 1: block select; access is `*_en & fb_en`.
- `bus_addr` in 8: byte address; `bus_addr[1:0]` ignored.
- `bus_write_data` in 32: write data.
- `bus_read_data` out 32: read data, combinational; 0 when no selected read.
- `pix_data` out 24: scaled GRB pixel to serializer; `pix_data[23]` sent first.
- `pix_valid` out 1: `pix_data` and `pix_last` valid.
- `pix_last` out 1: current pixel is the final one of the frame.
- `pix_ready` in 1: serializer accepts; transfer when `pix_valid & pix_ready`.
- `frame_done` out 1: one-cycle pulse after the last transfer.

## Operation
- Address map (word index = `bus_addr[7:2]`):
  - 0x00 + 4·i, i < `NPIX`: pixel i; write stores `bus_write_data[23:0]`, read returns `{8'b0, pixel}`.
  - 0x40 LEN: write `[4:0]`; 0 or > `NPIX` is stored as `NPIX`. Reset value `NPIX`.
  - 0x44 BRIGHT: write `[7:0]`. Reset value 0xFF.
  - 0x48 CTRL, write only: bit0 start; bit1 clear all pixels to 0; bit2 clear the done flag. Bit1 takes precedence over bit0.
  - 0x4C STATUS, read only: `{26'b0, done, busy, idx[3:0]}`. `idx` is the current pixel index.
  - Unmapped reads return 0. Unmapped writes have no effect.
- States:
  - IDLE: waits for a start command.
  - LOAD: reads `buf[idx]`, scales it, registers `pix_data`/`pix_last`.
  - OFFER: holds `pix_valid` high.
  - DONE: pulses `frame_done`.
- Transitions:
  - IDLE→LOAD on a start write; `idx` ← 0.
  - LOAD→OFFER always.
  - OFFER→LOAD on a transfer when `idx` ≠ LEN−1; `idx` increments.
  - OFFER→DONE on a transfer when `idx` = LEN−1.
  - DONE→IDLE always; the sticky `done` flag is set.
- `busy` = state ≠ IDLE.
- While busy:
  - Pixel, LEN, BRIGHT and start/clear writes are ignored.
  - CTRL bit2 (clear done) is honoured.
- Brightness scaling, applied per 8-bit channel: out = (c × (BRIGHT+1)) >> 8, using a 16-bit intermediate.
  - BRIGHT 0xFF gives identity.
  - BRIGHT 0x00 maps c = 0xFF to 0x00.
- `pix_last` = (`idx` = LEN−1), registered in LOAD.
- `pix_data` and `pix_last` are stable while `pix_valid` is high and not yet accepted.
- A write on the same cycle as DONE→IDLE is treated as an idle-cycle write.
- A clear-done write on the DONE cycle loses to the set: `done` ends at 1.

## Timing
- Reset values: `pix_valid` 0, `pix_data` 0, `pix_last` 0, `frame_done` 0, state IDLE, `idx` 0, `done` 0, all pixels 0.
- Start write on edge t: LOAD during cycle t+1, `pix_valid` high from t+2.
- Transfer at edge k (not last): `pix_valid` is low for one cycle (LOAD), then high again from k+2. Peak rate is one pixel per 2 cycles.
- Last transfer at edge k: `frame_done` high for cycle k+1; `busy` reads 0 from k+2.
- `nreset` asserted mid-frame: all outputs drop within the reset, with no `frame_done`. The buffer is cleared, and the downstream serializer is reset by the same net.
- Reads never stall and have no side effects.

## Test plan
- Reset with `pix_ready` held 1 → all outputs 0, STATUS reads 0x00000000, LEN reads as `NPIX` via internal state, `pix_valid` never rises.
- Write pixels 0..2 = 0x123456, 0xABCDEF, 0xFF00FF; LEN = 3; BRIGHT = 0xFF; start; `pix_ready` = 1 → three transfers of exactly those values. `pix_last` is set only on the third transfer, followed by a one-cycle `frame_done`, then STATUS = 0x20.
- BRIGHT = 0x7F, pixel 0 = 0xFF8001, LEN = 1, start → `pix_data` = 0x7F4000 with `pix_last` = 1.
- `pix_ready` low for 10 cycles in OFFER → `pix_valid`, `pix_data` and `pix_last` held constant. A pixel write during this window leaves buffer contents unchanged on readback.
- LEN write 0 → full `NPIX` frame sent. LEN write 20 with `NPIX` = 8 → 8 pixels. CTRL = 0x3 → buffer all zero, no frame started.
- Assert `nreset` while OFFER on pixel 2 of 4 → `pix_valid` drops immediately. After release, no `frame_done` occurs, `busy` = 0, and a new start sends from pixel 0.
